// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter with burst hold, locked transfers and SPLIT masking.
// Define AHB_ARBITER_SPLIT_EN to build the split mask; otherwise SPLIT behaves like RETRY.
module ahb_arbiter #(
  parameter int ARB_NUMBER = 2,
  parameter int DEF_MASTER = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [ARB_NUMBER-1:0] hbusreqx,
  input  logic [ARB_NUMBER-1:0] hlockx,
  input  logic [15:0]           hsplitx,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  output logic [ARB_NUMBER-1:0] hgrantx,
  output logic [3:0]            hmaster,
  output logic                  hmastlock
);
  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;
  localparam logic [ARB_NUMBER-1:0] DEF_OH = ARB_NUMBER'(1) << DEF_MASTER;
  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [ARB_NUMBER-1:0] mask, elig, sel_oh, grant_nxt;
  logic [3:0] cur;
  logic resp_first, keep_lock, fixed_ns, lock_g, lock_sel, unused_bits;
  assign unused_bits = ^{hsplitx, hburst[0]};
  assign resp_first = !hready && hresp != 2'd0;
  assign fixed_ns = htrans == 2'd2 && hburst[2:1] != 2'd0;
  assign lock_g = |(hlockx & hgrantx);
  assign lock_sel = |(hlockx & sel_oh);
  assign elig = hbusreqx & ~mask;
`ifdef AHB_ARBITER_SPLIT_EN
  logic [ARB_NUMBER-1:0] mask_nxt;
  assign keep_lock = state == LOCK && hresp == 2'd2;
  // set beats clear when a SPLIT and a resume hit the same master together
  always_comb begin
    mask_nxt = mask & ~hsplitx[ARB_NUMBER-1:0];
    for (int i = 0; i < ARB_NUMBER; i++)
      if (resp_first && hresp == 2'd3 && hmaster == 4'(i)) mask_nxt[i] = 1'b1;
  end
  always_ff @(posedge hclk) mask <= hreset ? '0 : mask_nxt;
`else
  assign keep_lock = state == LOCK && hresp[1];
  assign mask = '0;
`endif
  // search order starts just after the current grant; parked counts as the last master
  always_comb begin
    cur = 4'(ARB_NUMBER - 1);
    for (int i = 0; i < ARB_NUMBER; i++)
      if (hgrantx[i]) cur = 4'(i);
    sel_oh = mask[DEF_MASTER] ? '0 : DEF_OH;
    for (int i = ARB_NUMBER - 1; i >= 0; i--)
      if (elig[i] && 4'(i) <= cur) sel_oh = ARB_NUMBER'(1) << i;
    for (int i = ARB_NUMBER - 1; i >= 0; i--)
      if (elig[i] && 4'(i) > cur) sel_oh = ARB_NUMBER'(1) << i;
  end
  always_comb
    cnt_nxt = resp_first ? 5'd0 :
              !hready ? cnt :
              htrans == 2'd2 ? (hburst[2:1] == 2'd0 ? 5'd0 :
                                hburst[2:1] == 2'd1 ? 5'd3 :
                                hburst[2:1] == 2'd2 ? 5'd7 : 5'd15) :
              htrans == 2'd3 ? (cnt == 5'd0 ? 5'd0 : cnt - 5'd1) :
              htrans == 2'd0 ? 5'd0 : cnt;
  always_comb begin
    state_nxt = state;
    grant_nxt = hgrantx;
    if (resp_first)
      state_nxt = keep_lock ? LOCK : ARB;
    else if (hready && !((state == BURST && cnt_nxt > 5'd1) || (state == LOCK && lock_g))) begin
      if ((state == ARB && fixed_ns) || (state == LOCK && cnt_nxt > 5'd1))
        state_nxt = BURST;
      else begin
        grant_nxt = sel_oh;
        state_nxt = lock_sel ? LOCK : ARB;
      end
    end
  end
  always_ff @(posedge hclk)
    if (hreset) begin
      state <= ARB;
      cnt <= '0;
      hgrantx <= DEF_OH;
      hmaster <= 4'(DEF_MASTER);
      hmastlock <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      hgrantx <= grant_nxt;
      if (hready) begin
        hmaster <= |hgrantx ? cur : 4'd15;
        hmastlock <= lock_g;
      end
    end
endmodule
